// File: rtl/system_pkg.sv
// Shared constants, state encodings and helpers for the loopback self-test system.
package system_pkg;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 11;  // start + 8 data + stop + gap

    localparam logic [2:0] TX_ST_IDLE  = 3'd0;
    localparam logic [2:0] TX_ST_START = 3'd1;
    localparam logic [2:0] TX_ST_DATA  = 3'd2;
    localparam logic [2:0] TX_ST_STOP  = 3'd3;
    localparam logic [2:0] TX_ST_GAP   = 3'd4;

    localparam logic [1:0] RX_ST_IDLE  = 2'd0;
    localparam logic [1:0] RX_ST_START = 2'd1;
    localparam logic [1:0] RX_ST_DATA  = 2'd2;
    localparam logic [1:0] RX_ST_STOP  = 2'd3;

    typedef enum logic [2:0] {
        TX_IDLE  = TX_ST_IDLE,
        TX_START = TX_ST_START,
        TX_DATA  = TX_ST_DATA,
        TX_STOP  = TX_ST_STOP,
        TX_GAP   = TX_ST_GAP
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = RX_ST_IDLE,
        RX_START = RX_ST_START,
        RX_DATA  = RX_ST_DATA,
        RX_STOP  = RX_ST_STOP
    } rx_state_e;

    function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/system_uart_rx.sv
// 8N1 UART receiver with 2-FF input synchroniser, mid-bit sampling and
// single-cycle valid / frame-error pulses.
module uart_rx
    import system_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 43
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 rxd_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 frame_err_o
);

    localparam int unsigned CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);

    // [0],[1] synchroniser, [2] previous synchronised value for edge detect.
    // Held high in reset so the idle line does not look like a start edge.
    logic [2:0]           sync_q;
    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 line, fall;

    assign line = sync_q[1];
    assign fall = !sync_q[1] && sync_q[2];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], rxd_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (fall) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = line ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {line, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'(DATA_BITS - 1)) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (line) valid_d = 1'b1;
                    else      ferr_d  = 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign data_o      = shift_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;

endmodule

// File: rtl/system.sv
// Self-test top: heartbeat LED plus an incrementing-byte UART transmitter
// looped back into a checking receiver.
module system
    import system_pkg::*;
#(
    parameter int unsigned clk_freq       = 50000000,
    parameter int unsigned uart_baud_rate = 115200,
    parameter int unsigned blink_hz       = 1000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] leds
);

    localparam int unsigned BAUD_DIV = baud_div(clk_freq, uart_baud_rate);
    localparam int unsigned HB_DIV   = clk_freq / blink_hz;
    localparam int unsigned CW       = $clog2(BAUD_DIV);
    localparam int unsigned HW       = $clog2(HB_DIV);
    localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

    if (BAUD_DIV < 4 || FRAME_BITS != DATA_BITS + 3) begin : g_baud_chk
        $error("system: BAUD_DIV must be at least 4");
    end

    // Heartbeat
    logic [HW-1:0] hb_cnt_q;
    logic          hb_wrap;
    logic          led_hb_q;

    assign hb_wrap = (hb_cnt_q == HW'(HB_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hb_cnt_q <= '0;
            led_hb_q <= 1'b0;
        end else begin
            hb_cnt_q <= hb_wrap ? '0 : hb_cnt_q + 1'b1;
            if (hb_wrap) led_hb_q <= ~led_hb_q;
        end
    end

    // Transmitter: every state lasts one bit time; txd is registered from the
    // next state so the loopback line is glitch-free.
    tx_state_e            tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_byte_q, tx_byte_d;
    logic                 txd_q, txd_d;
    logic                 tx_tick;

    assign tx_tick = (tx_cnt_q == FULL_M1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_byte_q  <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_byte_q  <= tx_byte_d;
            txd_q      <= txd_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_tick ? '0 : tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_byte_d  = tx_byte_q;
        if (tx_tick) begin
            case (tx_state_q)
                TX_IDLE:  tx_state_d = TX_START;
                TX_START: begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = '0;
                end
                TX_DATA: begin
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'(DATA_BITS - 1)) tx_state_d = TX_STOP;
                end
                TX_STOP:  tx_state_d = TX_GAP;
                TX_GAP: begin
                    tx_state_d = TX_START;
                    tx_byte_d  = tx_byte_q + 1'b1;
                end
                default:  tx_state_d = TX_IDLE;
            endcase
        end
        case (tx_state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = tx_byte_d[tx_bit_d];
            default:  txd_d = 1'b1;
        endcase
    end

    // Internal loopback
    logic                 rxd;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid, rx_ferr;

    assign rxd = txd_q;

    uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk_i       (clk),
        .rst_ni      (rst),
        .rxd_i       (rxd),
        .data_o      (rx_data),
        .valid_o     (rx_valid),
        .frame_err_o (rx_ferr)
    );

    // Checker: any received byte resyncs the expectation, so one corrupted
    // byte costs a single error rather than a permanent mismatch.
    logic [DATA_BITS-1:0] exp_q, exp_d;
    logic                 led_good_q, led_good_d;
    logic                 led_err_q, led_err_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q      <= '0;
            led_good_q <= 1'b0;
            led_err_q  <= 1'b0;
        end else begin
            exp_q      <= exp_d;
            led_good_q <= led_good_d;
            led_err_q  <= led_err_d;
        end
    end

    always_comb begin
        exp_d      = exp_q;
        led_good_d = led_good_q;
        led_err_d  = led_err_q;
        if (rx_valid) begin
            if (rx_data == exp_q) led_good_d = ~led_good_q;
            else                  led_err_d  = 1'b1;
            exp_d = rx_data + 1'b1;
        end
        if (rx_ferr) led_err_d = 1'b1;
    end

    assign leds = {led_err_q, led_good_q, led_hb_q};

endmodule

// File: tb/tb_system.sv
// Randomised-timing bench for the loopback self-test system against a
// frame-level reference model.
module tb_system;

    localparam int CLK_F = 50000000;
    localparam int BAUD  = 5000000;
    localparam int BLINK = 20000;
    localparam int BD    = CLK_F / BAUD;
    localparam int HB    = CLK_F / BLINK;
    localparam int FRM   = 11 * BD;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] leds;
    int         cyc;
    int         n_chk = 0;
    int         n_bad = 0;

    system #(.clk_freq(CLK_F), .uart_baud_rate(BAUD), .blink_hz(BLINK)) dut (
        .clk  (clk),
        .rst  (rst),
        .leds (leds)
    );

    always #10 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Expected line level t clock edges after reset release.
    function automatic logic model_txd(input int t);
        int r, f, b;
        logic [7:0] v;
        if (t < BD) return 1'b1;
        r = t - BD;
        f = r / FRM;
        b = (r % FRM) / BD;
        v = 8'(f);
        if (b == 0) return 1'b0;
        if (b <= 8) return v[b-1];
        return 1'b1;
    endfunction

    // Good-LED toggles and error flag after nframes frames; frame 'bad' has a broken stop bit.
    function automatic void model_rx(input int nframes, input int bad, output int tog, output logic err);
        int exp_v, val;
        exp_v = 0; tog = 0; err = 1'b0;
        for (int f = 0; f < nframes; f++) begin
            val = f % 256;
            if (f == bad) begin
                err = 1'b1;
                continue;
            end
            if (val == exp_v) tog++;
            else              err = 1'b1;
            exp_v = (val + 1) % 256;
        end
    endfunction

    task automatic run(input int t_end, input int bad);
        int t, r, f, tog;
        logic err;
        do begin
            @(negedge clk);
            t = cyc;
            if (t == BD - 1 || t == BD) chk("txd_edge", 32'(dut.txd_q), 32'(model_txd(t)));
            if (t == HB - 1 || t == HB || t % HB == HB / 2)
                chk("heartbeat", 32'(leds[0]), 32'((t / HB) & 1));
            if (t >= BD) begin
                r = t - BD;
                f = r / FRM;
                if (r % BD == BD / 2 && (f < 3 || (f >= 254 && f < 258)))
                    chk("txd_bit", 32'(dut.txd_q), 32'(model_txd(t)));
                if (r % FRM == 50 && (f < 4 || f % 16 == 0 || (bad >= 0 && f >= bad - 1))) begin
                    model_rx(f, bad, tog, err);
                    chk("good_led", 32'(leds[1]), 32'(tog & 1));
                    chk("err_led", 32'(leds[2]), 32'(err));
                end
                if (bad >= 0 && r == bad * FRM + 91) force dut.rxd = 1'b0;
                if (bad >= 0 && r == bad * FRM + 99) release dut.rxd;
            end
        end while (t < t_end);
    endtask

    initial begin
        int extra;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_leds", 32'(leds), 32'd0);
            chk("rst_txd", 32'(dut.txd_q), 32'd1);
        end
        rst = 1'b1;
        // Long run through the byte wrap, with frame 275 given a broken stop bit.
        run(BD + 285 * FRM, 275);

        // Reset mid-frame at a random point inside the first few bits.
        extra = 30 + int'($urandom_range(0, 60));
        repeat (extra) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_leds", 32'(leds), 32'd0);
        chk("mid_rst_txd", 32'(dut.txd_q), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        run(BD + 4 * FRM, -1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
